// File: rtl/ex_result_stage_if.sv
// EX->MEM stage bundle: decode/ALU sideband in, buffered head entry and PC redirect out.
// slave = the result stage itself, master = whatever drives it and consumes its head.
interface ex_result_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  i_valid;
    logic                  o_ready;
    logic [XLEN-1:0]       i_alu_result;
    logic [XLEN-1:0]       i_rs2_data;
    logic [XLEN-1:0]       i_pc;
    logic [XLEN-1:0]       i_imm;
    logic [REG_ADDR_W-1:0] i_rd_addr;
    logic                  i_wb_en;
    logic                  i_mem_rd;
    logic                  i_mem_wr;
    logic [2:0]            i_funct3;
    logic                  i_is_branch;
    logic                  i_br_invert;
    logic                  i_is_jal;
    logic                  i_is_jalr;
    logic                  i_flush;
    logic                  o_redirect;
    logic [XLEN-1:0]       o_redirect_pc;
    logic                  o_valid;
    logic                  i_ready;
    logic [XLEN-1:0]       o_wb_data;
    logic [XLEN-1:0]       o_addr;
    logic [XLEN-1:0]       o_store_data;
    logic [REG_ADDR_W-1:0] o_rd_addr;
    logic                  o_wb_en;
    logic                  o_mem_rd;
    logic                  o_mem_wr;
    logic [2:0]            o_funct3;
    logic                  o_misaligned;

    modport slave (
        input  i_valid, i_alu_result, i_rs2_data, i_pc, i_imm, i_rd_addr, i_wb_en,
               i_mem_rd, i_mem_wr, i_funct3, i_is_branch, i_br_invert, i_is_jal,
               i_is_jalr, i_flush, i_ready,
        output o_ready, o_redirect, o_redirect_pc, o_valid, o_wb_data, o_addr,
               o_store_data, o_rd_addr, o_wb_en, o_mem_rd, o_mem_wr, o_funct3, o_misaligned
    );

    modport master (
        output i_valid, i_alu_result, i_rs2_data, i_pc, i_imm, i_rd_addr, i_wb_en,
               i_mem_rd, i_mem_wr, i_funct3, i_is_branch, i_br_invert, i_is_jal,
               i_is_jalr, i_flush, i_ready,
        input  o_ready, o_redirect, o_redirect_pc, o_valid, o_wb_data, o_addr,
               o_store_data, o_rd_addr, o_wb_en, o_mem_rd, o_mem_wr, o_funct3, o_misaligned
    );
endinterface

// File: rtl/ex_result_stage.sv
// Purpose: EX->MEM result stage, branch/jump resolution, 2-entry skid FIFO (MISALIGN_CHECK_EN adds alignment checks).
// Latency: accept in cycle N -> head at o_valid and o_redirect pulse in N+1 (empty FIFO).
// Backpressure: o_ready drops only when both entries are held; i_valid ignored during o_redirect.
module ex_result_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic              i_clk,
    input logic              i_rst_n,
    ex_result_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0]       wb_data;
        logic [XLEN-1:0]       addr;
        logic [XLEN-1:0]       store_data;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  wb_en;
        logic                  mem_rd;
        logic                  mem_wr;
        logic [2:0]            funct3;
        logic                  misaligned;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state_q, state_nxt;
    entry_t          head_q, tail_q, new_entry;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [XLEN-1:0] target;
    logic            taken, mem_mis, tgt_mis, any_mis;
    logic            ready, push, pop, redirect_set;
    logic            head_load_new, tail_load_new, head_from_tail;

    assign ready = (state_q != TWO);
    assign push  = bus.i_valid && ready && !redirect_q;
    assign pop   = (state_q != EMPTY) && bus.i_ready;

    assign taken  = (bus.i_is_branch && (bus.i_alu_result[0] ^ bus.i_br_invert))
                    || bus.i_is_jal || bus.i_is_jalr;
    assign target = bus.i_is_jalr ? (bus.i_alu_result & {{(XLEN-1){1'b1}}, 1'b0})
                                  : (bus.i_pc + bus.i_imm);

`ifdef MISALIGN_CHECK_EN
    assign mem_mis = (bus.i_mem_rd || bus.i_mem_wr) &&
                     ((bus.i_funct3[1:0] == 2'b01 && bus.i_alu_result[0]) ||
                      (bus.i_funct3[1:0] == 2'b10 && bus.i_alu_result[1:0] != 2'b00));
    assign tgt_mis = taken && target[1];
`else
    assign mem_mis = 1'b0;
    assign tgt_mis = 1'b0;
`endif
    assign any_mis = mem_mis || tgt_mis;

    // A misaligned jump target is reported through the entry instead of redirecting fetch.
    assign redirect_set = push && taken && !tgt_mis && !bus.i_flush;

    always_comb begin
        new_entry            = '0;
        new_entry.wb_data    = (bus.i_is_jal || bus.i_is_jalr) ? (bus.i_pc + XLEN'(4))
                                                               : bus.i_alu_result;
        new_entry.addr       = bus.i_alu_result;
        new_entry.store_data = bus.i_rs2_data;
        new_entry.rd_addr    = bus.i_rd_addr;
        new_entry.wb_en      = bus.i_wb_en;
        new_entry.mem_rd     = bus.i_mem_rd && !any_mis;
        new_entry.mem_wr     = bus.i_mem_wr && !any_mis;
        new_entry.funct3     = bus.i_funct3;
        new_entry.misaligned = any_mis;
    end

    always_comb begin
        state_nxt      = state_q;
        head_load_new  = 1'b0;
        tail_load_new  = 1'b0;
        head_from_tail = 1'b0;
        case (state_q)
            EMPTY: begin
                head_load_new = push;
                if (push) state_nxt = ONE;
            end
            ONE: begin
                head_load_new = push && pop;
                tail_load_new = push && !pop;
                if (push && !pop)      state_nxt = TWO;
                else if (!push && pop) state_nxt = EMPTY;
            end
            TWO: begin
                head_from_tail = pop;
                if (pop) state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
        if (bus.i_flush) state_nxt = EMPTY;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= EMPTY;
        else          state_q <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            if (head_load_new)       head_q <= new_entry;
            else if (head_from_tail) head_q <= tail_q;
            if (tail_load_new)       tail_q <= new_entry;
            redirect_q <= redirect_set;
            if (redirect_set) redirect_pc_q <= target;
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_valid       = (state_q != EMPTY);
    assign bus.o_redirect    = redirect_q;
    assign bus.o_redirect_pc = redirect_pc_q;
    assign bus.o_wb_data     = head_q.wb_data;
    assign bus.o_addr        = head_q.addr;
    assign bus.o_store_data  = head_q.store_data;
    assign bus.o_rd_addr     = head_q.rd_addr;
    assign bus.o_wb_en       = head_q.wb_en;
    assign bus.o_mem_rd      = head_q.mem_rd;
    assign bus.o_mem_wr      = head_q.mem_wr;
    assign bus.o_funct3      = head_q.funct3;
    assign bus.o_misaligned  = head_q.misaligned;

endmodule

// File: tb/tb_ex_result_stage.sv
// Randomized and directed bench for ex_result_stage against a queue-based reference model.
module tb_ex_result_stage;

`ifdef MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        bit          valid, ready, flush;
        logic [31:0] alu, rs2, pc, imm;
        logic [4:0]  rd;
        bit          wb_en, mem_rd, mem_wr;
        logic [2:0]  f3;
        bit          is_br, inv, jal, jalr;
    } stim_t;

    typedef struct {
        logic [31:0] wb_data, addr, store_data;
        logic [4:0]  rd;
        bit          wb_en, mem_rd, mem_wr, mis;
        logic [2:0]  f3;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    exp_t        q[$];
    bit          m_redir = 1'b0;
    logic [31:0] m_redir_pc = '0;

    ex_result_stage_if bus ();
    ex_result_stage dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        s.ready = 1'b1;
        return s;
    endfunction

    function automatic stim_t alu_op(input logic [31:0] v, input logic [4:0] rd);
        stim_t s = idle();
        s.valid = 1'b1; s.alu = v; s.rd = rd; s.wb_en = 1'b1;
        s.pc = 32'h1000 + {27'd0, rd} * 4;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = idle();
        int kind = $urandom_range(0, 5);
        s.valid = ($urandom_range(0, 3) != 0);
        s.ready = ($urandom_range(0, 3) != 0);
        s.flush = ($urandom_range(0, 31) == 0);
        s.alu = $urandom; s.rs2 = $urandom; s.pc = $urandom & 32'hFFFF_FFFC;
        s.imm = $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        s.rd = 5'($urandom);
        s.f3 = 3'($urandom);
        case (kind)
            0: s.wb_en = 1'b1;
            1: begin s.mem_rd = 1'b1; s.wb_en = 1'b1; end
            2: s.mem_wr = 1'b1;
            3: begin s.is_br = 1'b1; s.inv = 1'($urandom); end
            4: begin s.jal = 1'b1; s.wb_en = 1'b1; end
            default: begin s.jalr = 1'b1; s.wb_en = 1'b1; end
        endcase
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.i_valid = s.valid;  bus.i_ready = s.ready;   bus.i_flush = s.flush;
        bus.i_alu_result = s.alu; bus.i_rs2_data = s.rs2; bus.i_pc = s.pc; bus.i_imm = s.imm;
        bus.i_rd_addr = s.rd;   bus.i_wb_en = s.wb_en;   bus.i_mem_rd = s.mem_rd;
        bus.i_mem_wr = s.mem_wr; bus.i_funct3 = s.f3;    bus.i_is_branch = s.is_br;
        bus.i_br_invert = s.inv; bus.i_is_jal = s.jal;   bus.i_is_jalr = s.jalr;
    endtask

    // Reference: queue of at most two instructions plus a pending-redirect flag.
    task automatic model_update(input stim_t s);
        bit          acc, deq, tk, mmis, tmis;
        logic [31:0] tgt;
        exp_t        e;
        acc = s.valid && (q.size() < 2) && !m_redir;
        deq = (q.size() != 0) && s.ready;
        tk  = (s.is_br && (s.alu[0] != s.inv)) || s.jal || s.jalr;
        tgt = s.jalr ? {s.alu[31:1], 1'b0} : s.pc + s.imm;
        mmis = MIS_EN && (s.mem_rd || s.mem_wr) &&
               ((s.f3[1:0] == 2'd1 && s.alu[0]) || (s.f3[1:0] == 2'd2 && s.alu[1:0] != 2'd0));
        tmis = MIS_EN && tk && tgt[1];
        e.wb_data = (s.jal || s.jalr) ? s.pc + 32'd4 : s.alu;
        e.addr = s.alu; e.store_data = s.rs2; e.rd = s.rd; e.wb_en = s.wb_en; e.f3 = s.f3;
        e.mis = mmis || tmis;
        e.mem_rd = s.mem_rd && !e.mis;
        e.mem_wr = s.mem_wr && !e.mis;
        if (s.flush) begin
            q.delete();
            m_redir = 1'b0;
        end else begin
            if (deq) q.delete(0);
            if (acc) q.push_back(e);
            m_redir = acc && tk && !tmis;
            if (m_redir) m_redir_pc = tgt;
        end
    endtask

    task automatic check_model();
        exp_t e;
        chk("valid", 32'(bus.o_valid), 32'(q.size() != 0));
        chk("ready", 32'(bus.o_ready), 32'(q.size() < 2));
        chk("redirect", 32'(bus.o_redirect), 32'(m_redir));
        if (m_redir) chk("redirect_pc", bus.o_redirect_pc, m_redir_pc);
        if (q.size() != 0) begin
            e = q[0];
            chk("wb_data", bus.o_wb_data, e.wb_data);
            chk("addr", bus.o_addr, e.addr);
            chk("store_data", bus.o_store_data, e.store_data);
            chk("rd_addr", 32'(bus.o_rd_addr), 32'(e.rd));
            chk("ctl", {25'd0, bus.o_wb_en, bus.o_mem_rd, bus.o_mem_wr, bus.o_funct3, bus.o_misaligned},
                {25'd0, e.wb_en, e.mem_rd, e.mem_wr, e.f3, e.mis});
        end
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        check_model();
        apply(s);
        model_update(s);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (3) step(idle());
    endtask

    initial begin
        stim_t s;
        apply(idle());
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_redirect", 32'(bus.o_redirect), 32'd0);
        chk("rst_redirect_pc", bus.o_redirect_pc, 32'd0);
        chk("rst_wb_data", bus.o_wb_data, 32'd0);
        chk("rst_misaligned", 32'(bus.o_misaligned), 32'd0);
        rst_n = 1'b1;

        // back-to-back ALU ops at full rate
        for (int i = 0; i < 4; i++) step(alu_op(32'hA000_0000 + 32'(i), 5'(i + 1)));
        drain();

        // backpressure: three offered, two held
        s = alu_op(32'h0000_0B01, 5'd7); s.ready = 1'b0; step(s);
        s = alu_op(32'h0000_0B02, 5'd8); s.ready = 1'b0; step(s);
        after_edge();
        chk("bp_full_ready", 32'(bus.o_ready), 32'd0);
        s = alu_op(32'h0000_0B03, 5'd9); s.ready = 1'b0; step(s);
        drain();

        // taken BEQ, wrong-path instruction squashed
        s = idle(); s.valid = 1'b1; s.is_br = 1'b1; s.alu = 32'd1; s.pc = 32'h100; s.imm = 32'h20;
        step(s);
        after_edge();
        chk("beq_redirect", 32'(bus.o_redirect), 32'd1);
        chk("beq_target", bus.o_redirect_pc, 32'h120);
        step(alu_op(32'hDEAD_BEEF, 5'd3));
        after_edge();
        chk("beq_pulse_end", 32'(bus.o_redirect), 32'd0);
        chk("squash_valid", 32'(bus.o_valid), 32'd0);
        drain();

        // BNE with result 1: not taken
        s = idle(); s.valid = 1'b1; s.is_br = 1'b1; s.inv = 1'b1; s.alu = 32'd1; s.pc = 32'h200; s.imm = 32'h40;
        step(s);
        after_edge();
        chk("bne_no_redirect", 32'(bus.o_redirect), 32'd0);
        drain();

        // JALR
        s = idle(); s.valid = 1'b1; s.jalr = 1'b1; s.alu = 32'h205; s.pc = 32'h40; s.wb_en = 1'b1; s.rd = 5'd1;
        step(s);
        after_edge();
        chk("jalr_redirect", 32'(bus.o_redirect), 32'd1);
        chk("jalr_target", bus.o_redirect_pc, 32'h204);
        chk("jalr_link", bus.o_wb_data, 32'h44);
        drain();

        // flush cancels a same-cycle taken accept
        s = alu_op(32'h11, 5'd2); s.ready = 1'b0; step(s);
        s = idle(); s.valid = 1'b1; s.is_br = 1'b1; s.alu = 32'd1; s.pc = 32'h300; s.imm = 32'h8;
        s.ready = 1'b0; s.flush = 1'b1; step(s);
        after_edge();
        chk("flush1_valid", 32'(bus.o_valid), 32'd0);
        chk("flush1_redirect", 32'(bus.o_redirect), 32'd0);
        // flush with FIFO full and redirect outstanding
        s = alu_op(32'h22, 5'd4); s.ready = 1'b0; step(s);
        s = idle(); s.valid = 1'b1; s.is_br = 1'b1; s.alu = 32'd1; s.pc = 32'h400; s.imm = 32'h10;
        s.ready = 1'b0; step(s);
        s = idle(); s.ready = 1'b0; s.flush = 1'b1; step(s);
        after_edge();
        chk("flush2_valid", 32'(bus.o_valid), 32'd0);
        chk("flush2_redirect", 32'(bus.o_redirect), 32'd0);
        chk("flush2_ready", 32'(bus.o_ready), 32'd1);
        drain();

        // misaligned SW, aligned LW
        s = idle(); s.valid = 1'b1; s.mem_wr = 1'b1; s.f3 = 3'b010; s.alu = 32'h1002; s.rs2 = 32'h55AA;
        step(s);
        after_edge();
        chk("sw_misaligned", 32'(bus.o_misaligned), 32'(MIS_EN));
        chk("sw_mem_wr", 32'(bus.o_mem_wr), 32'(!MIS_EN));
        drain();
        s = idle(); s.valid = 1'b1; s.mem_rd = 1'b1; s.wb_en = 1'b1; s.f3 = 3'b010; s.alu = 32'h1004;
        step(s);
        after_edge();
        chk("lw_misaligned", 32'(bus.o_misaligned), 32'd0);
        chk("lw_mem_rd", 32'(bus.o_mem_rd), 32'd1);
        drain();

        for (int i = 0; i < 3000; i++) step(rand_stim());

        // asynchronous reset in the middle of traffic
        for (int i = 0; i < 20; i++) begin
            s = rand_stim(); s.flush = 1'b0; step(s);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 32'd0);
        chk("arst_redirect", 32'(bus.o_redirect), 32'd0);
        chk("arst_ready", 32'(bus.o_ready), 32'd1);
        chk("arst_addr", bus.o_addr, 32'd0);
        q.delete();
        m_redir = 1'b0;
        apply(idle());
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) step(rand_stim());
        @(negedge clk);
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
